// File: rtl/pc_gen.sv
// Fetch-stage program counter with trap/mret/branch redirects and misalign trapping.
// Latency: one cycle from request to pc_out / pulse outputs; all outputs registered.
// Backpressure: fetch_ready=0 or hold=1 freezes sequential advance; redirects ignore both.
module pc_gen #(
    parameter int                XLEN        = 64,
    parameter logic [XLEN-1:0]   RESET_VEC   = XLEN'(64'h0000_0000_8000_0000),
    parameter int                ILEN_BYTES  = 4,
    parameter int                CAUSE_W     = 6,
    parameter int                VECTORED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 fetch_ready,
    input  logic                 rel_branch,
    input  logic                 abs_branch,
    input  logic [XLEN-1:0]      branch_base,
    input  logic [XLEN-1:0]      immediate,
    input  logic                 exception,
    input  logic                 exc_interrupt,
    input  logic [CAUSE_W-1:0]   exc_cause,
    input  logic [XLEN-1:0]      mtvec,
    input  logic                 mret,
    input  logic [XLEN-1:0]      mepc,
    output logic [XLEN-1:0]      pc_out,
    output logic                 pc_valid,
    output logic                 redirect_o,
    output logic                 misalign_o,
    output logic [XLEN-1:0]      misalign_addr
);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_TRAP_WAIT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] INC_VAL    = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   maddr_q, maddr_d;

    logic [XLEN-1:0]   tvec_base;
    logic [XLEN-1:0]   cause_off;
    logic              vectored_hit;
    logic [XLEN-1:0]   trap_tgt;
    logic [XLEN-1:0]   mret_tgt;
    logic [XLEN-1:0]   rel_tgt;
    logic [XLEN-1:0]   abs_tgt;
    logic [XLEN-1:0]   br_tgt;
    logic              br_misaligned;

    // Only interrupts are vectored; synchronous exceptions and reserved modes use the base.
    always_comb begin
        tvec_base    = {mtvec[XLEN-1:2], 2'b00};
        cause_off    = XLEN'(exc_cause) << 2;
        vectored_hit = (VECTORED_EN != 0) && (mtvec[1:0] == 2'b01) && exc_interrupt;
        trap_tgt     = vectored_hit ? (tvec_base + cause_off) : tvec_base;
        mret_tgt     = mepc & ~ALIGN_MASK;
        rel_tgt      = branch_base + immediate;
        abs_tgt      = {immediate[XLEN-1:1], 1'b0};
        br_tgt        = rel_branch ? rel_tgt : abs_tgt;
        br_misaligned = (br_tgt & ALIGN_MASK) != '0;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        maddr_d    = maddr_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                pc_d    = RESET_VEC;
                valid_d = 1'b1;
            end

            ST_RUN: begin
                if (exception) begin
                    pc_d       = trap_tgt;
                    valid_d    = 1'b1;
                    redirect_d = 1'b1;
                end else if (mret) begin
                    pc_d       = mret_tgt;
                    valid_d    = 1'b1;
                    redirect_d = 1'b1;
                end else if (rel_branch || abs_branch) begin
                    // A faulting target leaves pc_out where it was for trap reporting.
                    if (br_misaligned) begin
                        misalign_d = 1'b1;
                        maddr_d    = br_tgt;
                        valid_d    = 1'b0;
                        state_d    = ST_TRAP_WAIT;
                    end else begin
                        pc_d       = br_tgt;
                        valid_d    = 1'b1;
                        redirect_d = 1'b1;
                    end
                end else if (valid_q && fetch_ready && !hold) begin
                    pc_d = pc_q + INC_VAL;
                end
            end

            ST_TRAP_WAIT: begin
                valid_d = 1'b0;
                if (exception) begin
                    pc_d       = trap_tgt;
                    valid_d    = 1'b1;
                    redirect_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            maddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            maddr_q    <= maddr_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_valid      = valid_q;
    assign redirect_o    = redirect_q;
    assign misalign_o    = misalign_q;
    assign misalign_addr = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboarded bench for pc_gen: directed plan then randomized traffic against a reference model.
module tb_pc_gen;

    localparam logic [63:0] RST_VEC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst, hold, fetch_ready, rel_branch, abs_branch;
    logic [63:0] branch_base, immediate, mtvec, mepc;
    logic        exception, exc_interrupt, mret;
    logic [5:0]  exc_cause;
    logic [63:0] pc_out, misalign_addr;
    logic        pc_valid, redirect_o, misalign_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .hold(hold), .fetch_ready(fetch_ready),
        .rel_branch(rel_branch), .abs_branch(abs_branch),
        .branch_base(branch_base), .immediate(immediate),
        .exception(exception), .exc_interrupt(exc_interrupt), .exc_cause(exc_cause),
        .mtvec(mtvec), .mret(mret), .mepc(mepc),
        .pc_out(pc_out), .pc_valid(pc_valid), .redirect_o(redirect_o),
        .misalign_o(misalign_o), .misalign_addr(misalign_addr)
    );

    typedef struct {
        logic [63:0] pc;
        logic        vld;
        logic        red;
        logic        mis;
        logic [63:0] maddr;
    } exp_t;

    exp_t sbq[$];

    typedef enum {P_BOOT, P_RUN, P_WAIT} phase_t;
    phase_t      m_ph = P_BOOT;
    logic [63:0] m_pc = RST_VEC;
    logic [63:0] m_maddr = 64'd0;
    logic        m_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: what the outputs must show after the coming clock edge.
    task automatic model_edge();
        exp_t        e;
        logic [63:0] tgt;
        logic        red = 1'b0;
        logic        mis = 1'b0;
        if (rst) begin
            m_pc = RST_VEC; m_valid = 1'b0; m_maddr = 64'd0; m_ph = P_BOOT;
        end else if (m_ph == P_BOOT) begin
            m_pc = RST_VEC; m_valid = 1'b1; m_ph = P_RUN;
        end else if (exception) begin
            tgt = mtvec - (mtvec % 4);
            if ((mtvec % 4) == 1 && exc_interrupt)
                tgt = tgt + 64'(exc_cause) * 4;
            m_pc = tgt; m_valid = 1'b1; red = 1'b1; m_ph = P_RUN;
        end else if (m_ph == P_WAIT) begin
            m_valid = 1'b0;
        end else if (mret) begin
            m_pc = mepc - (mepc % 4); m_valid = 1'b1; red = 1'b1;
        end else if (rel_branch || abs_branch) begin
            tgt = rel_branch ? branch_base + immediate : immediate - (immediate % 2);
            if ((tgt % 4) != 0) begin
                mis = 1'b1; m_maddr = tgt; m_valid = 1'b0; m_ph = P_WAIT;
            end else begin
                m_pc = tgt; m_valid = 1'b1; red = 1'b1;
            end
        end else if (m_valid && fetch_ready && !hold) begin
            m_pc = m_pc + 4;
        end
        e.pc = m_pc; e.vld = m_valid; e.red = red; e.mis = mis; e.maddr = m_maddr;
        sbq.push_back(e);
    endtask

    task automatic idle();
        rst = 1'b0; hold = 1'b0; fetch_ready = 1'b0;
        rel_branch = 1'b0; abs_branch = 1'b0; exception = 1'b0; mret = 1'b0;
        exc_interrupt = 1'b0; exc_cause = 6'd0;
        branch_base = 64'd0; immediate = 64'd0; mtvec = 64'd0; mepc = 64'd0;
    endtask

    // Inputs are set by the caller; returns 2 time units after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge the DUT presents a full output set; compare to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_pc_out",        pc_out,        e.pc);
                chk("sb_pc_valid",      64'(pc_valid),  64'(e.vld));
                chk("sb_redirect",      64'(redirect_o), 64'(e.red));
                chk("sb_misalign",      64'(misalign_o), 64'(e.mis));
                chk("sb_misalign_addr", misalign_addr, e.maddr);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        #2;
        step(); step();
        chk("reset_pc", pc_out, RST_VEC);
        chk("reset_valid", 64'(pc_valid), 64'd0);
        chk("reset_misalign_addr", misalign_addr, 64'd0);

        idle(); step();
        chk("boot_pc", pc_out, RST_VEC);
        chk("boot_valid", 64'(pc_valid), 64'd1);

        fetch_ready = 1'b1;
        step(); chk("seq1", pc_out, 64'h8000_0004);
        step(); chk("seq2", pc_out, 64'h8000_0008);
        step(); chk("seq3", pc_out, 64'h8000_000C);
        step(); chk("seq4", pc_out, 64'h8000_0010);

        fetch_ready = 1'b0;
        step(); step(); chk("stall_nordy", pc_out, 64'h8000_0010);
        fetch_ready = 1'b1; hold = 1'b1;
        step(); chk("stall_hold", pc_out, 64'h8000_0010);

        rel_branch = 1'b1; branch_base = 64'h8000_0010; immediate = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        chk("rel_hold_pc", pc_out, 64'h8000_0008);
        chk("rel_hold_redirect", 64'(redirect_o), 64'd1);
        idle(); step();
        chk("redirect_once", 64'(redirect_o), 64'd0);

        abs_branch = 1'b1; immediate = 64'h8000_0102;
        step();
        chk("abs_mis_pulse", 64'(misalign_o), 64'd1);
        chk("abs_mis_addr", misalign_addr, 64'h8000_0102);
        chk("abs_mis_pc", pc_out, 64'h8000_0008);
        chk("abs_mis_valid", 64'(pc_valid), 64'd0);
        idle(); mret = 1'b1; mepc = 64'h8000_0400;
        step();
        chk("wait_mret_ignored", 64'(pc_valid), 64'd0);
        chk("wait_mis_held", misalign_addr, 64'h8000_0102);
        idle(); exception = 1'b1; mtvec = 64'h8000_1001;
        step();
        chk("trap_exc_pc", pc_out, 64'h8000_1000);
        chk("trap_exc_valid", 64'(pc_valid), 64'd1);

        idle(); exception = 1'b1; exc_interrupt = 1'b1; exc_cause = 6'd7; mtvec = 64'h8000_2001;
        step(); chk("vec_irq", pc_out, 64'h8000_201C);
        exc_interrupt = 1'b0;
        step(); chk("vec_exc", pc_out, 64'h8000_2000);

        idle(); exception = 1'b1; rel_branch = 1'b1; mret = 1'b1; mtvec = 64'h9000_0000;
        branch_base = 64'h100; immediate = 64'h2; mepc = 64'h1234;
        step(); chk("prio_exc", pc_out, 64'h9000_0000);
        idle(); mret = 1'b1; mepc = 64'h8000_0406;
        step(); chk("mret_align", pc_out, 64'h8000_0404);

        idle(); rel_branch = 1'b1; branch_base = 64'hFFFF_FFFF_FFFF_FFFC; immediate = 64'd8;
        step(); chk("rel_wrap", pc_out, 64'h4);
        idle(); abs_branch = 1'b1; immediate = 64'hFFFF_FFFF_FFFF_FFFD;
        step(); chk("abs_bit0", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(); fetch_ready = 1'b1;
        step(); chk("seq_wrap", pc_out, 64'h0);

        idle(); rel_branch = 1'b1; abs_branch = 1'b1; branch_base = 64'h1000; immediate = 64'h2;
        step(); chk("rel_over_abs_mis", misalign_addr, 64'h1002);
        idle(); rst = 1'b1;
        step(); chk("rst_in_wait_valid", 64'(pc_valid), 64'd0);
        idle(); step();
        chk("rst_in_wait_pc", pc_out, RST_VEC);
        chk("rst_in_wait_vld", 64'(pc_valid), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) < 2);
            exception     = ($urandom_range(0, 99) < 8);
            mret          = ($urandom_range(0, 99) < 10);
            rel_branch    = ($urandom_range(0, 99) < 12);
            abs_branch    = ($urandom_range(0, 99) < 12);
            hold          = ($urandom_range(0, 99) < 30);
            fetch_ready   = ($urandom_range(0, 99) < 70);
            exc_interrupt = $urandom_range(0, 1) == 1;
            exc_cause     = 6'($urandom);
            branch_base   = {32'($urandom), 32'($urandom)};
            immediate     = {32'($urandom), 32'($urandom)};
            mtvec         = {32'($urandom), 32'($urandom)};
            mepc          = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) != 0) branch_base[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) immediate[1:0] = 2'b00;
            step();
        end

        idle();
        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
